// File: rtl/spi_regbank_peripheral.sv
// rtl/spi_regbank_peripheral.sv - SPI mode-0 register-bank slave with read-back
// All SPI pins are oversampled in the clk domain; nothing is clocked by SCLK.
module spi_regbank_peripheral #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         CIPO_OE,
  output logic [NUM_REGS*DATA_W-1:0]   REGS,
  output logic                         WR_STROBE,
  output logic [ADDR_W-1:0]            WR_ADDR,
  output logic                         FRAME_ERR
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] CNT_CMD        = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME      = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, ncs_s1, ncs_s2, copi_s1, copi_s2;
  logic sync_valid, ncs_armed;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic [CNT_W-1:0]          bit_cnt;
  logic [FRAME_W-1:0]        rx_shift;
  logic [DATA_W-1:0]         tx_shift;
  logic                      tx_load;
  logic                      overrun;
  logic                      cipo_q, cipo_oe_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                      wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]         wr_addr_q;

  logic                      rx_rw;
  logic [ADDR_W-1:0]         rx_addr;
  logic [DATA_W-1:0]         rx_data;
  logic [ADDR_W-1:0]         ld_addr;
  logic [DATA_W-1:0]         rd_val;
  logic                      addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1    <= 1'b0;
      sclk_s2    <= 1'b0;
      ncs_s1     <= 1'b1;
      ncs_s2     <= 1'b1;
      copi_s1    <= 1'b0;
      copi_s2    <= 1'b0;
      sync_valid <= 1'b0;
      ncs_armed  <= 1'b0;
    end else begin
      sclk_s1    <= SCLK;
      sclk_s2    <= sclk_s1;
      ncs_s1     <= nCS;
      ncs_s2     <= ncs_s1;
      copi_s1    <= COPI;
      copi_s2    <= copi_s1;
      sync_valid <= 1'b1;
      // A frame may only start after nCS has really been seen high since reset.
      if (sync_valid && ncs_s1)
        ncs_armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s1 & ~sclk_s2 & ~ncs_s2;
  assign sclk_fall = ~sclk_s1 & sclk_s2 & ~ncs_s2;
  assign ncs_rise  = ncs_s1 & ~ncs_s2;
  assign ncs_fall  = ~ncs_s1 & ncs_s2 & ncs_armed;

  assign rx_rw   = rx_shift[FRAME_W-1];
  assign rx_addr = rx_shift[FRAME_W-2 -: ADDR_W];
  assign rx_data = rx_shift[DATA_W-1:0];
  assign ld_addr = rx_shift[ADDR_W-1:0];
  assign addr_ok = ({1'b0, rx_addr} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ld_addr == ADDR_W'(k))
        rd_val = regs_q[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ncs_fall) state_d = CMD;
        CMD:     if (sclk_rise && bit_cnt == CNT_CMD_LAST) state_d = DATA;
        DATA:    if (sclk_rise && bit_cnt == CNT_FRAME_LAST) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_load     <= 1'b0;
      overrun     <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      tx_load     <= 1'b0;
      if (ncs_rise) begin
        cipo_oe_q <= 1'b0;
        cipo_q    <= 1'b0;
        if (state_q != IDLE) begin
          if (bit_cnt != CNT_FRAME || overrun) begin
            frame_err_q <= 1'b1;
          end else if (rx_rw && addr_ok) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (rx_addr == ADDR_W'(k))
                regs_q[k*DATA_W +: DATA_W] <= rx_data;
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= rx_addr;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (ncs_fall) begin
              bit_cnt  <= '0;
              rx_shift <= '0;
              tx_shift <= '0;
              overrun  <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[FRAME_W-2:0], copi_s2};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_CMD_LAST)
                tx_load <= ~rx_shift[CMD_W-2];
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[FRAME_W-2:0], copi_s2};
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            // The falling edge right after the last address bit precedes the
            // first data sample, so shifting starts only once a data bit has been clocked.
            if (tx_load) begin
              tx_shift  <= {rd_val[DATA_W-2:0], 1'b0};
              cipo_q    <= rd_val[DATA_W-1];
              cipo_oe_q <= 1'b1;
            end else if (sclk_fall && cipo_oe_q && bit_cnt > CNT_CMD) begin
              cipo_q   <= tx_shift[DATA_W-1];
              tx_shift <= tx_shift << 1;
            end
          end
          DONE: begin
            if (sclk_rise)
              overrun <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign CIPO      = cipo_q;
  assign CIPO_OE   = cipo_oe_q;
  assign REGS      = regs_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// tb/tb_spi_regbank_peripheral.sv - self-checking bench for spi_regbank_peripheral
// Table of directed frames, hand sequences for reset mid-frame, and random frames vs a register-array model.
module tb_spi_regbank_peripheral;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int HALF     = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        nCS = 1'b1;
  logic        COPI = 1'b0;
  logic        CIPO, CIPO_OE, WR_STROBE, FRAME_ERR;
  logic [NUM_REGS*DATA_W-1:0] REGS;
  logic [ADDR_W-1:0]          WR_ADDR;

  spi_regbank_peripheral #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(nCS), .COPI(COPI),
    .CIPO(CIPO), .CIPO_OE(CIPO_OE), .REGS(REGS), .WR_STROBE(WR_STROBE),
    .WR_ADDR(WR_ADDR), .FRAME_ERR(FRAME_ERR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] model [NUM_REGS];

  always @(negedge clk) begin
    if (WR_STROBE) begin
      strobe_cnt++;
      last_wr_addr = WR_ADDR;
    end
    if (FRAME_ERR) ferr_cnt++;
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         nbits;
    int         exp_strobe;
    int         exp_err;
    logic [7:0] exp_rd;
    logic       chk_rd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = model[k];
    return f;
  endfunction

  task automatic cs_low();
    nCS = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    nCS = 1'b1;
    COPI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // CIPO/CIPO_OE are sampled just before SCLK rises, as a controller would.
  task automatic send_bit(input logic b, output logic cipo_s, output logic oe_s);
    COPI = b;
    repeat (HALF) @(negedge clk);
    cipo_s = CIPO;
    oe_s = CIPO_OE;
    SCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, output logic [7:0] rd, output logic oe_ok);
    logic [15:0] w;
    logic c, o;
    w = {rw, addr, data};
    rd = '0;
    oe_ok = 1'b1;
    cs_low();
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < 16) ? w[15-i] : 1'b0, c, o);
      if (i >= 8 && i < 16) begin
        rd[15-i] = c;
        if (!o) oe_ok = 1'b0;
      end
    end
    cs_high();
  endtask

  task automatic check_frame(input string name, input vec_t v);
    int s0, e0;
    logic [7:0] rd;
    logic oe_ok;
    s0 = strobe_cnt;
    e0 = ferr_cnt;
    run_frame(v.rw, v.addr, v.data, v.nbits, rd, oe_ok);
    if (v.nbits == 16 && v.rw && v.addr < NUM_REGS) model[v.addr] = v.data;
    chk({name, ".strobes"}, 64'(strobe_cnt - s0), 64'(v.exp_strobe));
    chk({name, ".frame_err"}, 64'(ferr_cnt - e0), 64'(v.exp_err));
    if (v.exp_strobe != 0) chk({name, ".wr_addr"}, 64'(last_wr_addr), 64'(v.addr));
    if (v.chk_rd) begin
      chk({name, ".rd_data"}, 64'(rd), 64'(v.exp_rd));
      chk({name, ".oe_in_frame"}, 64'(oe_ok), 64'd1);
    end
    chk({name, ".regs"}, 64'(REGS), 64'(model_flat()));
    chk({name, ".oe_idle"}, 64'({CIPO_OE, CIPO}), 64'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    vec_t v;
    logic c, o;
    logic [15:0] w;
    int s0, e0, r;

    tbl[0] = '{1'b1, 7'h02, 8'hA5, 16, 1, 0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 7'h04, 8'h3C, 16, 1, 0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 7'h04, 8'h00, 16, 0, 0, 8'h3C, 1'b1};
    tbl[3] = '{1'b1, 7'h00, 8'h77, 10, 0, 1, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 7'h01, 8'hFF, 17, 0, 1, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 7'h7F, 8'h11, 16, 0, 0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 7'h7F, 8'h00, 16, 0, 0, 8'h00, 1'b1};
    tbl[7] = '{1'b0, 7'h02, 8'h00, 16, 0, 0, 8'hA5, 1'b1};
    tbl[8] = '{1'b0, 7'h00, 8'h00, 10, 0, 1, 8'h00, 1'b0};

    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

    repeat (3) @(negedge clk);
    chk("reset.regs", 64'(REGS), 64'd0);
    chk("reset.cipo", 64'(CIPO), 64'd0);
    chk("reset.cipo_oe", 64'(CIPO_OE), 64'd0);
    chk("reset.wr_strobe", 64'(WR_STROBE), 64'd0);
    chk("reset.wr_addr", 64'(WR_ADDR), 64'd0);
    chk("reset.frame_err", 64'(FRAME_ERR), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 9; i++) check_frame($sformatf("vec%0d", i), tbl[i]);

    // Reset pulse after 12 bits with nCS held low: nothing may commit.
    s0 = strobe_cnt;
    e0 = ferr_cnt;
    w = {1'b1, 7'h01, 8'h99};
    cs_low();
    for (int i = 0; i < 12; i++) send_bit(w[15-i], c, o);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.regs_cleared", 64'(REGS), 64'd0);
    chk("midrst.oe", 64'(CIPO_OE), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    for (int i = 12; i < 16; i++) send_bit(w[15-i], c, o);
    cs_high();
    chk("midrst.strobes", 64'(strobe_cnt - s0), 64'd0);
    chk("midrst.frame_err", 64'(ferr_cnt - e0), 64'd0);
    chk("midrst.regs", 64'(REGS), 64'd0);
    v = '{1'b1, 7'h03, 8'h5A, 16, 1, 0, 8'h00, 1'b0};
    check_frame("after_rst", v);

    for (int n = 0; n < 20; n++) begin
      v.rw = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      v.addr = (r == 7) ? 7'h7F : 7'(r);
      v.data = 8'($urandom);
      r = int'($urandom_range(0, 9));
      v.nbits = (r == 0) ? 10 : (r == 1) ? 17 : 16;
      v.exp_err = (v.nbits != 16) ? 1 : 0;
      v.exp_strobe = (v.exp_err == 0 && v.rw && v.addr < NUM_REGS) ? 1 : 0;
      v.exp_rd = (v.addr < NUM_REGS) ? model[v.addr] : 8'h00;
      v.chk_rd = !v.rw && v.nbits >= 16;
      check_frame($sformatf("rand%0d", n), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
